// File: rtl/storage_bist.sv
// storage_bist: drives a 16-step D/TClk sequence into a latch and two flip-flops.
// It checks their outputs once per step and reports sticky per-element fail flags
// together with the step index of the first failure.
module storage_bist #(
    parameter logic [15:0] PATTERN = 16'hA5C3,
    parameter int unsigned HOLD    = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Qa,
    input  logic       Qb,
    input  logic       Qc,
    output logic       D,
    output logic       TClk,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [2:0] FailMask,
    output logic [3:0] FailStep
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t     state, state_next;
    logic [3:0] step, step_next;
    logic [2:0] phase, phase_next;
    logic [7:0] holdcnt, holdcnt_next;
    logic       d_next, tclk_next;
    logic [2:0] mask_next;
    logic [3:0] fstep_next;
    logic       last_cycle;
    logic       sample;
    logic [2:0] mismatch;

    // D value for a given phase of step k. Phase 0 keeps the previous D, so that
    // D and TClk never move in the same cycle.
    function automatic logic drive_d(input logic [2:0] p, input logic [3:0] k, input logic cur);
        logic v;
        v = cur;
        case (p)
            3'd1, 3'd2, 3'd4: v = PATTERN[k];
            3'd3:             v = ~PATTERN[k];
            default:          v = cur;
        endcase
        return v;
    endfunction

    // Sample point and per-element comparison against the expected trio values.
    // Qc is skipped in step 0 because its negedge flop has not yet captured this run's data.
    always_comb begin
        last_cycle  = (holdcnt == HOLD_LAST);
        sample      = (state == RUN) && (phase == 3'd3) && last_cycle;
        mismatch    = 3'b000;
        mismatch[0] = (Qa != ~PATTERN[step]);
        mismatch[1] = (Qb != PATTERN[step]);
        mismatch[2] = (step != 4'd0) && (Qc != PATTERN[step - 4'd1]);
    end

    // Next-state, counter, drive and result logic.
    always_comb begin
        state_next   = state;
        step_next    = step;
        phase_next   = phase;
        holdcnt_next = holdcnt;
        d_next       = D;
        tclk_next    = TClk;
        mask_next    = FailMask;
        fstep_next   = FailStep;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    state_next   = RUN;
                    step_next    = 4'd0;
                    phase_next   = 3'd0;
                    holdcnt_next = 8'd0;
                    mask_next    = 3'b000;
                    fstep_next   = 4'd0;
                    tclk_next    = 1'b0;
                end
            end
            RUN: begin
                if (sample) begin
                    mask_next = FailMask | mismatch;
                    if ((FailMask == 3'b000) && (mismatch != 3'b000)) begin
                        fstep_next = step;
                    end
                end
                if (!last_cycle) begin
                    holdcnt_next = holdcnt + 8'd1;
                end else begin
                    holdcnt_next = 8'd0;
                    if (phase == 3'd4) begin
                        if (step == 4'd15) begin
                            state_next = DONE;
                        end else begin
                            step_next  = step + 4'd1;
                            phase_next = 3'd0;
                        end
                    end else begin
                        phase_next = phase + 3'd1;
                    end
                end
                if (state_next == RUN) begin
                    d_next    = drive_d(phase_next, step_next, D);
                    tclk_next = (phase_next >= 3'd2);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter, drive and result registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            step     <= 4'd0;
            phase    <= 3'd0;
            holdcnt  <= 8'd0;
            D        <= 1'b0;
            TClk     <= 1'b0;
            FailMask <= 3'b000;
            FailStep <= 4'd0;
        end else begin
            state    <= state_next;
            step     <= step_next;
            phase    <= phase_next;
            holdcnt  <= holdcnt_next;
            D        <= d_next;
            TClk     <= tclk_next;
            FailMask <= mask_next;
            FailStep <= fstep_next;
        end
    end

    assign Busy = (state == RUN);
    assign Done = (state == DONE);
    assign Pass = (state == DONE) && (FailMask == 3'b000);

endmodule

// File: tb/tb_storage_bist.sv
// tb_storage_bist: drives storage_bist with behavioural storage trios.
// Faults are injected into the trio outputs, and the results are compared with a step-level reference model.
module tb_storage_bist;

    localparam logic [15:0] PAT = 16'hA5C3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic qa_a, qb_a, qc_a, d_a, tclk_a, busy_a, done_a, pass_a;
    logic [2:0] mask_a;
    logic [3:0] fstep_a;
    logic qa_b, qb_b, qc_b, d_b, tclk_b, busy_b, done_b, pass_b;
    logic [2:0] mask_b;
    logic [3:0] fstep_b;

    int checks = 0;
    int errors = 0;

    // Wiring faults and per-step inversion faults on instance a.
    int qa_src = 0;
    int qc_src = 0;
    logic inj_en = 1'b0;
    int inj_step [3] = '{16, 16, 16};
    int cnt_a = 0;

    // Clock generation.
    always #5 clk = ~clk;

    storage_bist #(.PATTERN(PAT), .HOLD(1)) dut_a (
        .Clk(clk), .Reset(reset), .Start(start_a),
        .Qa(qa_a), .Qb(qb_a), .Qc(qc_a),
        .D(d_a), .TClk(tclk_a), .Busy(busy_a), .Done(done_a), .Pass(pass_a),
        .FailMask(mask_a), .FailStep(fstep_a)
    );

    storage_bist #(.PATTERN(PAT), .HOLD(3)) dut_b (
        .Clk(clk), .Reset(reset), .Start(start_b),
        .Qa(qa_b), .Qb(qb_b), .Qc(qc_b),
        .D(d_b), .TClk(tclk_b), .Busy(busy_b), .Done(done_b), .Pass(pass_b),
        .FailMask(mask_b), .FailStep(fstep_b)
    );

    // Behavioural trio for instance a: gated latch, posedge flop, negedge flop.
    logic lat_a = 1'b0;
    logic pos_a = 1'b0;
    logic neg_a = 1'b0;
    always_latch if (tclk_a) lat_a <= d_a;
    always @(posedge tclk_a) pos_a <= d_a;
    always @(negedge tclk_a) neg_a <= d_a;

    // Behavioural trio for instance b.
    logic lat_b = 1'b0;
    logic pos_b = 1'b0;
    logic neg_b = 1'b0;
    always_latch if (tclk_b) lat_b <= d_b;
    always @(posedge tclk_b) pos_b <= d_b;
    always @(negedge tclk_b) neg_b <= d_b;

    // Cycle index within the current run of instance a, used to locate the injected fault step.
    always @(posedge clk or posedge reset) begin
        if (reset) cnt_a <= 0;
        else if (busy_a) cnt_a <= cnt_a + 1;
        else cnt_a <= 0;
    end

    assign qa_a = ((qa_src != 0) ? pos_a : lat_a) ^ (inj_en && (inj_step[0] == cnt_a / 5));
    assign qb_a = pos_a ^ (inj_en && (inj_step[1] == cnt_a / 5));
    assign qc_a = ((qc_src != 0) ? pos_a : neg_a) ^ (inj_en && (inj_step[2] == cnt_a / 5));
    assign qa_b = lat_b;
    assign qb_b = pos_b;
    assign qc_b = neg_b;

    // Counts cycles in which D and TClk moved together, ignoring intervals that contain a reset.
    int viol = 0;
    int rst_cnt = 0;
    int rst_seen = 0;
    logic pd_a = 1'b0, pt_a = 1'b0, pd_b = 1'b0, pt_b = 1'b0;
    always @(negedge clk) begin
        if ((rst_seen == rst_cnt) && !reset) begin
            if ((d_a !== pd_a) && (tclk_a !== pt_a)) viol++;
            if ((d_b !== pd_b) && (tclk_b !== pt_b)) viol++;
        end
        rst_seen = rst_cnt;
        pd_a = d_a;
        pt_a = tclk_a;
        pd_b = d_b;
        pt_b = tclk_b;
    end

    // Pulse start on instance a and measure the Busy length; flags a timeout.
    task automatic run_a(output int n, output bit to);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        to = 1'b0;
        n = 0;
        while (!busy_a && n < 10) begin @(posedge clk); #1; n++; end
        if (!busy_a) begin to = 1'b1; n = 0; return; end
        n = 0;
        while (busy_a && n < 2000) begin @(posedge clk); #1; n++; end
        if (busy_a) to = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({d_a, tclk_a, busy_a, done_a, pass_a, mask_a, fstep_a} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_a: got %b expected 0", {d_a, tclk_a, busy_a, done_a, pass_a, mask_a, fstep_a});
        end
        checks++;
        if ({d_b, tclk_b, busy_b, done_b, pass_b, mask_b, fstep_b} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_b: got %b expected 0", {d_b, tclk_b, busy_b, done_b, pass_b, mask_b, fstep_b});
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a, busy_b, done_b} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL idle_wait: got %b expected 0000", {busy_a, done_a, busy_b, done_b});
        end
    endtask

    task automatic test_clean_run();
        logic [15:0] pat;
        logic exp_d, prev_d;
        int k, p;
        pat = PAT;
        prev_d = 1'b0;
        qa_src = 0; qc_src = 0; inj_en = 1'b0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int c = 0; c < 80; c++) begin
            k = c / 5;
            p = c % 5;
            case (p)
                0: exp_d = prev_d;
                3: exp_d = ~pat[k];
                default: exp_d = pat[k];
            endcase
            prev_d = exp_d;
            checks++;
            if ({busy_a, tclk_a, d_a} !== {1'b1, (p >= 2), exp_d}) begin
                errors++;
                $display("[TB] FAIL wave c=%0d: got busy/tclk/d %b expected %b", c,
                         {busy_a, tclk_a, d_a}, {1'b1, (p >= 2), exp_d});
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({busy_a, done_a, pass_a, mask_a, fstep_a} !== {3'b011, 3'b000, 4'd0}) begin
            errors++;
            $display("[TB] FAIL clean_done: got %b expected 0110000000", {busy_a, done_a, pass_a, mask_a, fstep_a});
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a, pass_a} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL done_stable: got %b expected 011", {busy_a, done_a, pass_a});
        end
    endtask

    task automatic test_wiring_faults();
        int n;
        bit to;
        qa_src = 1; qc_src = 0; inj_en = 1'b0;
        run_a(n, to);
        checks++;
        if (to || n != 80 || {pass_a, mask_a, fstep_a} !== {1'b0, 3'b001, 4'd0}) begin
            errors++;
            $display("[TB] FAIL qa_fault: got len=%0d to=%0d pass/mask/step %b expected 80 0 %b",
                     n, to, {pass_a, mask_a, fstep_a}, {1'b0, 3'b001, 4'd0});
        end
        qa_src = 0; qc_src = 1;
        run_a(n, to);
        checks++;
        if (to || n != 80 || {pass_a, mask_a, fstep_a} !== {1'b0, 3'b100, 4'd2}) begin
            errors++;
            $display("[TB] FAIL qc_fault: got len=%0d to=%0d pass/mask/step %b expected 80 0 %b",
                     n, to, {pass_a, mask_a, fstep_a}, {1'b0, 3'b100, 4'd2});
        end
        qc_src = 0;
    endtask

    task automatic test_random_faults();
        int n;
        bit to;
        logic [2:0] exp_mask;
        int exp_step;
        for (int it = 0; it < 10; it++) begin
            for (int x = 0; x < 3; x++) begin
                if ($urandom_range(0, 2) == 0) inj_step[x] = 16;
                else inj_step[x] = int'($urandom_range(0, 15));
            end
            exp_mask = 3'b000;
            exp_step = 16;
            for (int x = 0; x < 3; x++) begin
                if (inj_step[x] < 16 && !(x == 2 && inj_step[x] == 0)) begin
                    exp_mask[x] = 1'b1;
                    if (inj_step[x] < exp_step) exp_step = inj_step[x];
                end
            end
            if (exp_step == 16) exp_step = 0;
            inj_en = 1'b1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_a(n, to);
            checks++;
            if (to || n != 80 || mask_a !== exp_mask || fstep_a !== 4'(exp_step)
                || pass_a !== (exp_mask == 3'b000)) begin
                errors++;
                $display("[TB] FAIL rand_fault it=%0d: got len=%0d mask=%b step=%0d pass=%b expected 80 mask=%b step=%0d pass=%b",
                         it, n, mask_a, fstep_a, pass_a, exp_mask, exp_step, (exp_mask == 3'b000));
            end
        end
        inj_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit to;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (37) @(posedge clk);
        #1;
        rst_cnt++;
        reset = 1'b1;
        #1;
        checks++;
        if ({d_a, tclk_a, busy_a, done_a, pass_a, mask_a, fstep_a} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %b expected 0", {d_a, tclk_a, busy_a, done_a, pass_a, mask_a, fstep_a});
        end
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got %b expected 00", {busy_a, done_a});
        end
        run_a(n, to);
        checks++;
        if (to || n != 80 || {pass_a, mask_a, fstep_a} !== {1'b1, 3'b000, 4'd0}) begin
            errors++;
            $display("[TB] FAIL rerun_after_reset: got len=%0d to=%0d pass/mask/step %b expected 80 0 10000000",
                     n, to, {pass_a, mask_a, fstep_a});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        inj_step = '{16, 5, 16};
        inj_en = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (busy_a && n < 200) begin @(posedge clk); #1; n++; end
        inj_en = 1'b0;
        checks++;
        if (n != 80 || {done_a, pass_a, mask_a, fstep_a} !== {2'b10, 3'b010, 4'd5}) begin
            errors++;
            $display("[TB] FAIL b2b_first: got len=%0d done/pass/mask/step %b expected 80 %b",
                     n, {done_a, pass_a, mask_a, fstep_a}, {2'b10, 3'b010, 4'd5});
        end
        @(posedge clk); #1;
        checks++;
        if ({busy_a, done_a, mask_a, fstep_a} !== {2'b10, 3'b000, 4'd0}) begin
            errors++;
            $display("[TB] FAIL b2b_reenter: got busy/done/mask/step %b expected 100000000", {busy_a, done_a, mask_a, fstep_a});
        end
        n = 0;
        while (busy_a && n < 200) begin @(posedge clk); #1; n++; end
        start_a = 1'b0;
        checks++;
        if (n != 80 || {done_a, pass_a, mask_a} !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL b2b_second: got len=%0d done/pass/mask %b expected 80 11000", n, {done_a, pass_a, mask_a});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a, pass_a} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL b2b_hold_done: got %b expected 011", {busy_a, done_a, pass_a});
        end
        inj_step = '{16, 16, 16};
    endtask

    task automatic test_hold3();
        int n, rises, bad, last;
        logic pt;
        for (int run = 0; run < 2; run++) begin
            start_b = 1'b1;
            if (run == 0) begin @(posedge clk); #1; end
            n = 0; rises = 0; bad = 0; last = -1; pt = tclk_b;
            while (busy_b && n < 1000) begin
                if (tclk_b && !pt) begin
                    if (last >= 0 && (n - last) != 15) bad++;
                    rises++;
                    last = n;
                end
                pt = tclk_b;
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (n != 240 || rises != 16 || bad != 0) begin
                errors++;
                $display("[TB] FAIL hold3_run%0d: got len=%0d rises=%0d bad_periods=%0d expected 240 16 0", run, n, rises, bad);
            end
            checks++;
            if ({done_b, pass_b, mask_b, fstep_b} !== {2'b11, 3'b000, 4'd0}) begin
                errors++;
                $display("[TB] FAIL hold3_done%0d: got %b expected 110000000", run, {done_b, pass_b, mask_b, fstep_b});
            end
            if (run == 0) begin
                @(posedge clk); #1;
                checks++;
                if ({busy_b, done_b} !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL hold3_one_cycle_done: got busy/done %b expected 10", {busy_b, done_b});
                end
            end
        end
        start_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_drive_separation();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("[TB] FAIL d_tclk_same_cycle: got %0d violations expected 0", viol);
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_clean_run();
        test_wiring_faults();
        test_random_faults();
        test_reset_mid_run();
        test_back_to_back();
        test_hold3();
        test_drive_separation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit, so the bench ends even if a DUT event never occurs.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no completion expected finish");
        $fatal(1, "[TB] time limit");
    end

endmodule
